uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receiver: the receive end of the serial link the system's UART transmits on. Feeds the system's uart_rx path.
- Deserialises 8N1 frames from an asynchronous rx line into a small byte FIFO that the CPU-side logic pops.
- Flags framing errors and overruns.
- Bit timing comes from a programmable clocks-per-bit divider, not a separate baud clock.

Parameters:
- CLKS_PER_BIT, 16, system clocks per serial bit (>= 4).
- FIFO_DEPTH, 4, received-byte buffer depth (power of two).
- CNT_W, 8, width of the bit-period counter (must hold CLKS_PER_BIT-1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- rx  input  1  serial input; idle high; asynchronous to clk.
- rd  input  1  pop request; one byte is popped per cycle while rd=1 and valid=1.
- data  output  8  head-of-FIFO byte; valid only while valid=1.
- valid  output  1  FIFO not empty.
- full  output  1  FIFO holds FIFO_DEPTH bytes.
- frame_err  output  1  sticky; a stop bit was sampled low.
- overrun  output  1  sticky; a byte completed while the FIFO was full.
- clr_err  input  1  synchronous clear of frame_err and overrun.
- busy  output  1  receiver is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; FIFO is empty; both pointers and the counter are 0.
  - data=0, valid=0, full=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops reset to 1.
  - A frame in progress is abandoned. After release the receiver waits for a fresh falling edge.
- Input sync: rx passes through two flops (rx_s). All decisions use rx_s, giving 2 cycles of latency from pin to FSM.
- FSM:
  - IDLE: if rx_s=0, go to START and load counter=0.
  - START: count to CLKS_PER_BIT/2-1 (mid start bit). If rx_s=0 there, go to DATA with counter=0 and bit index=0. If rx_s=1, treat it as a glitch and return to IDLE; nothing is pushed and no flag is set.
  - DATA: sample rx_s when the counter reaches CLKS_PER_BIT-1, then reset the counter. Shift the bit in LSB first. After bit index 7, go to STOP.
  - STOP: sample at counter=CLKS_PER_BIT-1.
    - rx_s=1: push the byte (or flag overrun) and go to IDLE.
    - rx_s=0: set frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- busy=1 in START, DATA, STOP and BREAK.
- Timing: the stop sample lands at about 9.5 bit periods after the falling edge. The receiver is back in IDLE roughly 0.5 bit before the stop bit ends, so back-to-back frames with no idle gap are received.
- FIFO:
  - Write pointer, read pointer and a count of log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
  - data is driven combinationally from mem[rd_ptr].
  - A pushed byte appears on data with valid=1 on the cycle after the stop sample edge (1-cycle latency).
  - Push when full: byte dropped, overrun set, FIFO unchanged.
  - Push and pop in the same cycle when full: the pop frees the slot, so the push succeeds, count is unchanged and overrun is not set.
  - Push and pop in the same cycle when empty: the pop is ignored (valid=0), the push succeeds, count=1.
  - rd while empty: no effect; pointers unchanged.
- Flags:
  - frame_err and overrun stay set until clr_err=1.
  - If clr_err and a set event occur in the same cycle, set wins.
- Arithmetic: the counter is CNT_W bits and never exceeds CLKS_PER_BIT-1. The bit index is 3 bits.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
1. Send 0x55 (8N1, 16 clk/bit) after reset → valid rises 1 cycle after the stop sample, data=0x55, frame_err=0. Pulse rd once → valid=0.
2. Send 0xA5, 0x3C, 0xFF back-to-back with no idle gap, no rd → pops yield 0xA5, 0x3C, 0xFF in order; full=0; overrun=0.
3. Low glitch of 4 clk on rx in IDLE → receiver returns to IDLE, busy drops, valid=0, no flags set.
4. Send 0x81 with stop bit driven 0, then hold rx low 40 clk and release → frame_err=1, no byte pushed, no second frame decoded. Pulse clr_err → frame_err=0.
5. Fill the FIFO with 0x01..0x04, then send 0x05 with no rd → full=1, overrun=1, pops return 0x01..0x04. Repeat, asserting rd on the 0x06 stop-sample cycle → 0x06 accepted, overrun not newly set.
6. Assert rst=0 mid-DATA of 0x77 → outputs go to reset values immediately. Release rst and send 0x12 → exactly one byte 0x12 received.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// uart_rx_fifo : 8N1 UART receiver with 2-flop input sync and a byte FIFO
// Revision     : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       full,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]      C_DEPTH    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic             w_push;
  logic             w_frame_set;
  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  logic             w_ovr_set;

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == C_CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == C_CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == C_CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            w_push  = 1'b1;
            state_d = S_IDLE;
          end else begin
            w_frame_set = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    w_pop     = rd && (count_q != '0);
    w_full    = (count_q == C_DEPTH);
    w_push_ok = w_push && (!w_full || w_pop);
    w_ovr_set = w_push && w_full && !w_pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW + 1)'(w_push_ok) - (AW + 1)'(w_pop);

    frame_err_d = w_frame_set ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
    overrun_d   = w_ovr_set   ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = mem_q[rd_ptr_q];
  assign valid     = (count_q != '0);
  assign full      = w_full;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// tb_uart_rx_fifo : directed + randomized bench against a queue-based model
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd;
  logic       clr_err;
  logic [7:0] data;
  logic       valid;
  logic       full;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] q[$];
  logic       m_ferr = 1'b0;
  logic       m_ovr  = 1'b0;

  uart_rx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd        (rd),
    .data      (data),
    .valid     (valid),
    .full      (full),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first nsym symbols of an 8N1 frame, 16 clocks each; rx is left at the last symbol.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int nsym);
    logic [9:0] sym;
    sym = {stop, b, 1'b0};
    for (int i = 0; i < nsym; i++) begin
      rx = sym[i];
      tick(16);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop)                  m_ferr = 1'b1;
    else if (q.size() == DEPTH) m_ovr  = 1'b1;
    else                        q.push_back(b);
  endtask

  task automatic check_state(input string tag);
    check({tag, " valid"}, valid, (q.size() > 0));
    check({tag, " full"}, full, (q.size() == DEPTH));
    check({tag, " frame_err"}, frame_err, m_ferr);
    check({tag, " overrun"}, overrun, m_ovr);
    check({tag, " busy"}, busy, 1'b0);
    if (q.size() > 0) check({tag, " data"}, data, q[0]);
  endtask

  task automatic pop_one(input string tag);
    if (q.size() > 0) begin
      check({tag, " pop valid"}, valid, 1'b1);
      check({tag, " pop data"}, data, q[0]);
      void'(q.pop_front());
    end else begin
      check({tag, " pop empty"}, valid, 1'b0);
    end
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    logic       prev_stop;
    int         gap;
    int         npop;

    rst = 1'b0; rx = 1'b1; rd = 1'b0; clr_err = 1'b0;
    #12;
    check("reset data", data, 8'h00);
    check("reset valid", valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset flags", {full, frame_err, overrun}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(4);

    // Single frame: valid rises on the cycle after the stop-sample edge.
    fork
      send_frame(8'h55, 1'b1, 10);
      begin
        repeat (154) @(posedge clk);
        #2 check("t1 valid before stop sample", valid, 1'b0);
        @(posedge clk);
        #2 check("t1 valid after stop sample", valid, 1'b1);
        check("t1 data", data, 8'h55);
      end
    join
    model_frame(8'h55, 1'b1);
    check_state("t1");
    pop_one("t1");
    check_state("t1 after pop");

    // Back-to-back frames with no idle gap.
    send_frame(8'hA5, 1'b1, 10); model_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1, 10); model_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1, 10); model_frame(8'hFF, 1'b1);
    tick(2);
    check_state("t2");
    for (int i = 0; i < 3; i++) pop_one("t2");
    check_state("t2 drained");

    // Short low glitch is rejected at mid start bit.
    rx = 1'b0; tick(4); rx = 1'b1;
    tick(2);
    check("t3 busy during glitch", busy, 1'b1);
    tick(20);
    check_state("t3");

    // Stop bit low then line held low: one frame error, no byte, no re-trigger.
    send_frame(8'h81, 1'b0, 10);
    model_frame(8'h81, 1'b0);
    tick(40);
    check("t4 busy in break", busy, 1'b1);
    rx = 1'b1;
    tick(200);
    check_state("t4");
    clear_flags();
    check_state("t4 cleared");

    // Overrun on a push into a full FIFO.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 10);
      model_frame(8'(i), 1'b1);
    end
    tick(2);
    check_state("t5 full");
    for (int i = 0; i < 5; i++) pop_one("t5");
    clear_flags();
    check_state("t5 cleared");
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1, 10);
      model_frame(8'(i), 1'b1);
    end
    // Pop on the exact stop-sample cycle of 0x06 frees room for it.
    fork
      send_frame(8'h06, 1'b1, 10);
      begin
        repeat (154) @(posedge clk);
        #1;
        check("t5 head before concurrent pop", data, q[0]);
        check("t5 full before concurrent pop", full, 1'b1);
        rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    void'(q.pop_front());
    q.push_back(8'h06);
    tick(2);
    check_state("t5 concurrent");
    for (int i = 0; i < 4; i++) pop_one("t5b");
    check_state("t5b drained");

    // Asynchronous reset in the middle of a frame.
    send_frame(8'h5A, 1'b1, 10);
    model_frame(8'h5A, 1'b1);
    send_frame(8'h77, 1'b1, 4);
    #2 rst = 1'b0;
    #1;
    check("t6 reset data", data, 8'h00);
    check("t6 reset valid/busy", {valid, busy}, 2'b00);
    check("t6 reset flags", {full, frame_err, overrun}, 3'b000);
    q.delete(); m_ferr = 1'b0; m_ovr = 1'b0;
    rx = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    tick(5);
    send_frame(8'h12, 1'b1, 10);
    model_frame(8'h12, 1'b1);
    tick(30);
    check_state("t6");
    check("t6 one byte", dut.count_q, 3'd1);
    pop_one("t6");
    check_state("t6 drained");

    // Randomized frames, gaps, pops and clears against the model.
    prev_stop = 1'b1;
    for (int it = 0; it < 24; it++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      gap  = $urandom_range(0, 12);
      if (!prev_stop && gap < 3) gap = 3;
      tick(gap);
      send_frame(b, stop, 10);
      rx = 1'b1;
      model_frame(b, stop);
      tick(4);
      check_state($sformatf("rnd%0d", it));
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) pop_one($sformatf("rnd%0d", it));
      if ($urandom_range(0, 5) == 0) begin
        clear_flags();
        check_state($sformatf("rnd%0d clr", it));
      end
      prev_stop = stop;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
